serv_rf_stream: RTL and testbench



---
 rtl/serv_rf_pkg.sv | 44 ++++
 rtl/serv_rf_beat_ctr.sv | 66 ++++++
 rtl/serv_rf_stream.sv | 153 +++++++++++++++
 tb/tb_serv_rf_stream.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serv_rf_pkg.sv
// +--------------------------------------------------------------------+
// | serv_rf_pkg - shared types, FSM encodings and sizing helpers        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package serv_rf_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    CTR_IDLE = 1'b0,
    CTR_RUN  = 1'b1
  } ctr_state_t;

  localparam ctr_state_t R_IDLE = CTR_IDLE;
  localparam ctr_state_t R_RUN  = CTR_RUN;
  localparam ctr_state_t W_IDLE = CTR_IDLE;
  localparam ctr_state_t W_RUN  = CTR_RUN;

  function automatic bit legal_w(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32);
  endfunction

  function automatic bit legal_nregs(input int n);
    return (n == 16) || (n == 32);
  endfunction

  function automatic int beats_of(input int w);
    return XLEN / w;
  endfunction

  function automatic int cnt_width(input int w);
    return (XLEN / w > 1) ? $clog2(XLEN / w) : 1;
  endfunction

  // Nonzero and inside the implemented register range (bit 4 absent for RV32E).
  function automatic logic reg_ok(input logic [4:0] idx, input int nregs);
    return (idx != 5'd0) && ((nregs == 32) || !idx[4]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serv_rf_beat_ctr.sv
// +--------------------------------------------------------------------+
// | serv_rf_beat_ctr - idle/run FSM with beat counter for one stream    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module serv_rf_beat_ctr
  import serv_rf_pkg::*;
#(
  parameter int BEATS = 32,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          advance,
  output ctr_state_t    state,
  output logic [CW-1:0] cnt,
  output logic          last
);

  ctr_state_t    state_next;
  logic [CW-1:0] cnt_next;

  assign last = (state == CTR_RUN) && (cnt == CW'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CTR_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      CTR_IDLE: begin
        if (start) begin
          state_next = CTR_RUN;
          cnt_next   = '0;
        end
      end
      CTR_RUN: begin
        if (advance) begin
          if (last) begin
            state_next = CTR_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = CTR_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/serv_rf_stream.sv
// +--------------------------------------------------------------------+
// | serv_rf_stream - W-bit serial register file, 2 read / 1 write stream|
// | Optional feature macro: SERV_RF_BYPASS_EN (write-to-read forwarding)|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module serv_rf_stream
  import serv_rf_pkg::*;
#(
  parameter int W     = 1,
  parameter int NREGS = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_rreq,
  input  logic [4:0]   i_rs1_addr,
  input  logic [4:0]   i_rs2_addr,
  output logic         o_rvalid,
  output logic         o_rlast,
  output logic [W-1:0] o_rs1,
  output logic [W-1:0] o_rs2,
  input  logic         i_wreq,
  input  logic [4:0]   i_rd_addr,
  input  logic         i_rd_valid,
  input  logic [W-1:0] i_rd,
  output logic         o_wbusy,
  output logic         o_wdone
);

  localparam int BEATS = beats_of(W);
  localparam int CW    = cnt_width(W);
  localparam int RW    = $clog2(NREGS);
  localparam int DEPTH = NREGS * BEATS;
  localparam int AW    = $clog2(DEPTH);

  if (!legal_w(W) || !legal_nregs(NREGS)) begin : g_bad_param
    $error("serv_rf_stream: illegal W=%0d or NREGS=%0d", W, NREGS);
  end

  ctr_state_t    rd_state;
  ctr_state_t    wr_state;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;
  logic          rd_last;
  logic          wr_last;
  logic          rd_start;
  logic          wr_start;
  logic          rd_run;
  logic          wr_run;
  logic          wr_beat;
  logic          wr_store;
  logic [4:0]    rs1_q;
  logic [4:0]    rs2_q;
  logic [4:0]    rd_q;
  logic          wdone_q;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [AW-1:0] waddr;
  logic [W-1:0]  rs1_beat;
  logic [W-1:0]  rs2_beat;
  logic [W-1:0]  mem [DEPTH];

  assign rd_start = i_rreq && (rd_state == R_IDLE);
  assign wr_start = i_wreq && (wr_state == W_IDLE);
  assign rd_run   = (rd_state == R_RUN);
  assign wr_run   = (wr_state == W_RUN);
  assign wr_beat  = wr_run && i_rd_valid;
  // x0 and out-of-range beats still advance the stream, they just never land.
  assign wr_store = wr_beat && reg_ok(rd_q, NREGS);

  serv_rf_beat_ctr #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_rd_ctr (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .start   (rd_start),
    .advance (1'b1),
    .state   (rd_state),
    .cnt     (rd_cnt),
    .last    (rd_last)
  );

  serv_rf_beat_ctr #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_wr_ctr (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .start   (wr_start),
    .advance (i_rd_valid),
    .state   (wr_state),
    .cnt     (wr_cnt),
    .last    (wr_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wdone_q <= 1'b0;
    end else begin
      if (rd_start) begin
        rs1_q <= i_rs1_addr;
        rs2_q <= i_rs2_addr;
      end
      if (wr_start) begin
        rd_q <= i_rd_addr;
      end
      wdone_q <= wr_last && i_rd_valid;
    end
  end

  if (BEATS > 1) begin : g_multi_beat
    assign waddr  = {rd_q[RW-1:0], wr_cnt};
    assign raddr1 = {rs1_q[RW-1:0], rd_cnt};
    assign raddr2 = {rs2_q[RW-1:0], rd_cnt};
  end else begin : g_single_beat
    assign waddr  = rd_q[RW-1:0];
    assign raddr1 = rs1_q[RW-1:0];
    assign raddr2 = rs2_q[RW-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (wr_store) begin
      mem[waddr] <= i_rd;
    end
  end

  always_comb begin
    rs1_beat = mem[raddr1];
    rs2_beat = mem[raddr2];
`ifdef SERV_RF_BYPASS_EN
    // Register-validity is applied at the output mux, so only the match is needed here.
    if (wr_beat && rd_run && (rd_cnt == wr_cnt)) begin
      if (rs1_q == rd_q) rs1_beat = i_rd;
      if (rs2_q == rd_q) rs2_beat = i_rd;
    end
`endif
  end

  assign o_rs1    = (rd_run && reg_ok(rs1_q, NREGS)) ? rs1_beat : '0;
  assign o_rs2    = (rd_run && reg_ok(rs2_q, NREGS)) ? rs2_beat : '0;
  assign o_rvalid = rd_run;
  assign o_rlast  = rd_last;
  assign o_wbusy  = wr_run;
  assign o_wdone  = wdone_q;

endmodule

`default_nettype wire

// File: tb/tb_serv_rf_stream.sv
// +--------------------------------------------------------------------+
// | tb_serv_rf_stream - directed bench for serv_rf_stream (W=4 and W=1) |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_serv_rf_stream;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // W=4, NREGS=32 instance
  logic       rreq4 = 1'b0, wreq4 = 1'b0, rdv4 = 1'b0;
  logic [4:0] rs1a4 = '0, rs2a4 = '0, rda4 = '0;
  logic [3:0] rd4   = '0;
  logic       rvalid4, rlast4, wbusy4, wdone4;
  logic [3:0] rs1_4, rs2_4;

  // W=1, NREGS=16 instance
  logic       rreq1 = 1'b0, wreq1 = 1'b0, rdv1 = 1'b0;
  logic [4:0] rs1a1 = '0, rs2a1 = '0, rda1 = '0;
  logic [0:0] rd1   = '0;
  logic       rvalid1, rlast1, wbusy1, wdone1;
  logic [0:0] rs1_1, rs2_1;

  serv_rf_stream #(.W(4), .NREGS(32)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rreq(rreq4), .i_rs1_addr(rs1a4), .i_rs2_addr(rs2a4),
    .o_rvalid(rvalid4), .o_rlast(rlast4), .o_rs1(rs1_4), .o_rs2(rs2_4),
    .i_wreq(wreq4), .i_rd_addr(rda4), .i_rd_valid(rdv4), .i_rd(rd4),
    .o_wbusy(wbusy4), .o_wdone(wdone4)
  );

  serv_rf_stream #(.W(1), .NREGS(16)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rreq(rreq1), .i_rs1_addr(rs1a1), .i_rs2_addr(rs2a1),
    .o_rvalid(rvalid1), .o_rlast(rlast1), .o_rs1(rs1_1), .o_rs2(rs2_1),
    .i_wreq(wreq1), .i_rd_addr(rda1), .i_rd_valid(rdv1), .i_rd(rd1),
    .o_wbusy(wbusy1), .o_wdone(wdone1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int wdone_cnt4 = 0;
  int wdone_cnt1 = 0;

  always @(negedge clk) begin
    if (wdone4) wdone_cnt4 <= wdone_cnt4 + 1;
    if (wdone1) wdone_cnt1 <= wdone_cnt1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // sel=0 drives the W=4 instance, sel=1 the W=1 instance.
  task automatic wr_stream(input bit sel, input logic [4:0] a, input logic [31:0] d,
                           input bit gap, output int done_cyc, output bit busy_ok);
    int beats = sel ? 32 : 8;
    int k     = 0;
    int cyc   = 0;
    int abs_c;
    @(posedge clk); #1;
    if (sel) begin wreq1 = 1'b1; rda1 = a; end
    else     begin wreq4 = 1'b1; rda4 = a; end
    @(posedge clk); #1;
    wreq1   = 1'b0;
    wreq4   = 1'b0;
    busy_ok = 1'b1;
    while (k < beats && cyc < 4 * beats) begin
      logic v;
      v = !(gap && ((cyc % 2) == 1));
      if (sel) begin rdv1 = v; rd1 = d[k]; end
      else     begin rdv4 = v; rd4 = d[k*4 +: 4]; end
      #3;
      if (!(sel ? wbusy1 : wbusy4)) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (v) k++;
      cyc++;
    end
    rdv1     = 1'b0;
    rdv4     = 1'b0;
    done_cyc = -1;
    abs_c    = cyc + 1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if ((sel ? wdone1 : wdone4) && done_cyc < 0) done_cyc = abs_c;
      @(posedge clk); #1;
      abs_c++;
    end
    if (sel ? wbusy1 : wbusy4) busy_ok = 1'b0;
  endtask

  task automatic rd_stream(input bit sel, input logic [4:0] a1, input logic [4:0] a2,
                           input bit poke_last, output logic [31:0] v1,
                           output logic [31:0] v2, output int lastk, output int nvalid);
    int beats = sel ? 32 : 8;
    @(posedge clk); #1;
    if (sel) begin rreq1 = 1'b1; rs1a1 = a1; rs2a1 = a2; end
    else     begin rreq4 = 1'b1; rs1a4 = a1; rs2a4 = a2; end
    @(posedge clk); #1;
    rreq1  = 1'b0;
    rreq4  = 1'b0;
    v1     = '0;
    v2     = '0;
    lastk  = -1;
    nvalid = 0;
    for (int k = 0; k < beats; k++) begin
      @(negedge clk);
      if (sel ? rvalid1 : rvalid4) nvalid++;
      if ((sel ? rlast1 : rlast4) && lastk < 0) lastk = k;
      if (sel) begin v1[k] = rs1_1[0]; v2[k] = rs2_1[0]; end
      else     begin v1[k*4 +: 4] = rs1_4; v2[k*4 +: 4] = rs2_4; end
      if (poke_last && k == beats - 1) begin
        if (sel) rreq1 = 1'b1;
        else     rreq4 = 1'b1;
      end
    end
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      rreq1 = 1'b0;
      rreq4 = 1'b0;
      if (sel ? rvalid1 : rvalid4) nvalid++;
    end
  endtask

  initial begin
    logic [31:0] v1, v2, bypass_exp;
    int          lk, nv, dc;
    bit          bok;

    repeat (2) @(posedge clk);
    #1;
    check("reset_rvalid", 32'(rvalid4), 32'd0);
    check("reset_rlast",  32'(rlast4),  32'd0);
    check("reset_wbusy",  32'(wbusy4),  32'd0);
    check("reset_wdone",  32'(wdone4),  32'd0);
    check("reset_rs",     32'({rs1_4, rs2_4}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // x5 = DEADBEEF, streamed back on rs1 with x0 on rs2
    wr_stream(1'b0, 5'd5, 32'hDEADBEEF, 1'b0, dc, bok);
    check("t1_wdone_cycle", 32'(dc), 32'd9);
    check("t1_wbusy", 32'(bok), 32'd1);
    rd_stream(1'b0, 5'd5, 5'd0, 1'b0, v1, v2, lk, nv);
    check("t1_rs1", v1, 32'hDEADBEEF);
    check("t1_rs2_x0", v2, 32'h0);
    check("t1_rlast_beat", 32'(lk), 32'd7);
    check("t1_rvalid_beats", 32'(nv), 32'd8);
    check("t1_idle_rs1", 32'(rs1_4), 32'd0);
    check("t1_wdone_pulses", 32'(wdone_cnt4), 32'd1);

    // W=1: all-ones to x0 is dropped
    wr_stream(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, dc, bok);
    check("t2_wdone_cycle", 32'(dc), 32'd33);
    rd_stream(1'b1, 5'd0, 5'd0, 1'b0, v1, v2, lk, nv);
    check("t2_x0_read", v1, 32'h0);
    check("t2_rvalid_beats", 32'(nv), 32'd32);
    check("t2_rlast_beat", 32'(lk), 32'd31);

    // Stalled write: valid only on alternate cycles
    wr_stream(1'b0, 5'd3, 32'h12345678, 1'b1, dc, bok);
    check("t3_wdone_cycle", 32'(dc), 32'd16);
    check("t3_wbusy", 32'(bok), 32'd1);
    rd_stream(1'b0, 5'd3, 5'd5, 1'b0, v1, v2, lk, nv);
    check("t3_rs1", v1, 32'h12345678);
    check("t3_rs2", v2, 32'hDEADBEEF);

    // Beat-aligned overlapping write and read of x7
    wr_stream(1'b0, 5'd7, 32'h0, 1'b0, dc, bok);
    @(posedge clk); #1;
    rreq4 = 1'b1; wreq4 = 1'b1;
    rs1a4 = 5'd7; rs2a4 = 5'd7; rda4 = 5'd7;
    @(posedge clk); #1;
    rreq4 = 1'b0; wreq4 = 1'b0;
    rdv4  = 1'b1; rd4   = 4'hF;
    v1 = '0;
    v2 = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      v1[k*4 +: 4] = rs1_4;
      v2[k*4 +: 4] = rs2_4;
    end
    @(posedge clk); #1;
    rdv4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef SERV_RF_BYPASS_EN
    bypass_exp = 32'hFFFFFFFF;
`else
    bypass_exp = 32'h0;
`endif
    check("t4_overlap_rs1", v1, bypass_exp);
    check("t4_overlap_rs2", v2, bypass_exp);
    check("t4_wdone_pulses", 32'(wdone_cnt4), 32'd4);
    rd_stream(1'b0, 5'd7, 5'd0, 1'b0, v1, v2, lk, nv);
    check("t4_x7_after", v1, 32'hFFFFFFFF);

    // RV32E: x20 is out of range and must not alias onto x4
    wr_stream(1'b1, 5'd4, 32'h0, 1'b0, dc, bok);
    wr_stream(1'b1, 5'd20, 32'hAAAAAAAA, 1'b0, dc, bok);
    check("t5_oor_wdone_cycle", 32'(dc), 32'd33);
    rd_stream(1'b1, 5'd20, 5'd4, 1'b0, v1, v2, lk, nv);
    check("t5_x20_read", v1, 32'h0);
    check("t5_x4_read_rs2", v2, 32'h0);
    rd_stream(1'b1, 5'd4, 5'd20, 1'b1, v1, v2, lk, nv);
    check("t5_x4_read", v1, 32'h0);
    check("t5_rreq_last_ignored", 32'(nv), 32'd32);
    check("t5_wdone_pulses", 32'(wdone_cnt1), 32'd3);

    // Reset during beat 3 of a read
    @(posedge clk); #1;
    rreq4 = 1'b1; rs1a4 = 5'd5; rs2a4 = 5'd3;
    @(posedge clk); #1;
    rreq4 = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("t6_rvalid_beat3", 32'(rvalid4), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_rvalid", 32'(rvalid4), 32'd0);
    check("t6_async_rs1", 32'(rs1_4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_stream(1'b0, 5'd5, 5'd3, 1'b0, v1, v2, lk, nv);
    check("t6_restart_rs1", v1, 32'hDEADBEEF);
    check("t6_restart_rs2", v2, 32'h12345678);
    check("t6_restart_rlast", 32'(lk), 32'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
